// File: rtl/cla_lookahead_pipe_adder_pkg.sv
// Shared constants and the 4-input lookahead carry function for the pipelined CLA adder.
// lcu4 returns {c[3:1], PP, GG}; PP/GG never depend on cin.
package cla_pkg;

    localparam int SLICE_W      = 4;
    localparam int GROUP_SLICES = 4;

    function automatic logic [4:0] lcu4(input logic [3:0] p, input logic [3:0] g, input logic cin);
        logic [3:0] c;
        logic       gg;
        c[0] = cin;
        for (int k = 0; k < 3; k++) begin
            c[k+1] = g[k] | (p[k] & c[k]);
        end
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {c[3:1], &p, gg};
    endfunction

endpackage

// File: rtl/cla_lookahead_pipe_adder_lcu.sv
// Combinational 4-input lookahead carry unit, used per slice group and once across groups.
// PP/GG come from a cin-free evaluation so group propagate never depends on the group carry-in.
module cla_lcu_4
    import cla_pkg::*;
(
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] c,
    output logic       pp,
    output logic       gg
);

    logic [4:0] with_cin;
    logic [4:0] no_cin;
    logic [4:0] unused_bits;

    assign with_cin    = lcu4(p, g, cin);
    assign no_cin      = lcu4(p, g, 1'b0);
    assign c           = {with_cin[4:2], cin};
    assign pp          = no_cin[1];
    assign gg          = no_cin[0];
    assign unused_bits = {with_cin[1:0], no_cin[4:2]};

endmodule

// File: rtl/cla_lookahead_pipe_adder.sv
// Two-stage pipelined add/sub: stage 1 captures operand P/G and slice PP/GG, stage 2 runs the
// two-level lookahead, forms the sum and flags. Valid/ready handshake on both sides.
module cla_lookahead_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int NGROUP = NSLICE / GROUP_SLICES;

    logic adv1, adv2;
    logic s1_valid, s2_valid;

    logic [WIDTH-1:0]  b_eff, p_nxt, g_nxt;
    logic [NSLICE-1:0] sp_nxt, sg_nxt;

    logic [WIDTH-1:0]  s1_p, s1_g;
    logic [NSLICE-1:0] s1_pp, s1_gg;
    logic              s1_cin;

    logic [NGROUP-1:0] grp_pp, grp_gg;
    logic [3:0]        lvl2_p, lvl2_g, lvl2_c;
    logic              lvl2_pp, lvl2_gg;
    logic [5:0]        unused_lvl2;
    logic [NSLICE-1:0] slice_c;
    logic [WIDTH-1:0]  bit_c, sum_nxt;
    logic              c_out_nxt, ovf_nxt;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    assign b_eff = B ^ {WIDTH{sub}};
    assign p_nxt = A ^ b_eff;
    assign g_nxt = A & b_eff;

    always_comb begin
        sp_nxt = '0;
        sg_nxt = '0;
        for (int i = 0; i < NSLICE; i++) begin
            sp_nxt[i] = &p_nxt[SLICE_W*i +: SLICE_W];
            sg_nxt[i] = g_nxt[SLICE_W*i+3]
                      | (p_nxt[SLICE_W*i+3] & g_nxt[SLICE_W*i+2])
                      | (p_nxt[SLICE_W*i+3] & p_nxt[SLICE_W*i+2] & g_nxt[SLICE_W*i+1])
                      | (p_nxt[SLICE_W*i+3] & p_nxt[SLICE_W*i+2] & p_nxt[SLICE_W*i+1] & g_nxt[SLICE_W*i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_pp    <= '0;
            s1_gg    <= '0;
            s1_cin   <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p   <= p_nxt;
                s1_g   <= g_nxt;
                s1_pp  <= sp_nxt;
                s1_gg  <= sg_nxt;
                s1_cin <= sub;
            end
        end
    end

    // Level 1: slice carry-ins within each group of four slices.
    for (genvar gi = 0; gi < NGROUP; gi++) begin : g_lvl1
        cla_lcu_4 u_lcu (
            .p   (s1_pp[GROUP_SLICES*gi +: GROUP_SLICES]),
            .g   (s1_gg[GROUP_SLICES*gi +: GROUP_SLICES]),
            .cin (lvl2_c[gi]),
            .c   (slice_c[GROUP_SLICES*gi +: GROUP_SLICES]),
            .pp  (grp_pp[gi]),
            .gg  (grp_gg[gi])
        );
    end

    // Level 2: group carry-ins; absent groups are padded as kill (p=0, g=0).
    always_comb begin
        lvl2_p = '0;
        lvl2_g = '0;
        lvl2_p[NGROUP-1:0] = grp_pp;
        lvl2_g[NGROUP-1:0] = grp_gg;
    end

    cla_lcu_4 u_lvl2 (
        .p   (lvl2_p),
        .g   (lvl2_g),
        .cin (s1_cin),
        .c   (lvl2_c),
        .pp  (lvl2_pp),
        .gg  (lvl2_gg)
    );

    assign unused_lvl2 = {lvl2_c, lvl2_pp, lvl2_gg};

    always_comb begin
        bit_c = '0;
        for (int i = 0; i < NSLICE; i++) begin
            bit_c[SLICE_W*i] = slice_c[i];
            for (int k = 0; k < SLICE_W - 1; k++) begin
                bit_c[SLICE_W*i+k+1] = s1_g[SLICE_W*i+k] | (s1_p[SLICE_W*i+k] & bit_c[SLICE_W*i+k]);
            end
        end
    end

    assign sum_nxt   = s1_p ^ bit_c;
    assign c_out_nxt = s1_gg[NSLICE-1] | (s1_pp[NSLICE-1] & slice_c[NSLICE-1]);
    assign ovf_nxt   = bit_c[WIDTH-1] ^ c_out_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            S        <= '0;
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                S     <= sum_nxt;
                c_out <= c_out_nxt;
                ovf   <= ovf_nxt;
                zero  <= (sum_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_lookahead_pipe_adder.sv
// Self-checking bench: directed corner ops, back-pressure, async reset, and random streaming
// against an arithmetic reference model with an in-order scoreboard.
module tb_cla_lookahead_pipe_adder;

    localparam int W    = 32;
    localparam int NOPS = 10000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] S;
    logic         c_out, ovf, zero;

    cla_lookahead_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
        int           acc;
    } res_t;

    res_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        res_t   m;
        logic [W:0] w;
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!s) begin
            w   = {1'b0, a} + {1'b0, b};
            m.c = w[W];
            r   = sa + sb;
        end else begin
            w   = {1'b0, a} - {1'b0, b};
            m.c = (a >= b);
            r   = sa - sb;
        end
        m.s   = w[W-1:0];
        m.o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        m.z   = (m.s == '0);
        m.acc = 0;
        return m;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive after the edge, check at the falling edge, account the upcoming transfers.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ordy);
        res_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        A         = a;
        B         = b;
        sub       = s;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", in_ready, (q.size() < 2) || ordy);
        chk("out_valid", out_valid, (q.size() > 0) && (cyc >= q[0].acc + 2));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk("result", {S, c_out, ovf, zero}, {e.s, e.c, e.o, e.z});
            end
        end
        if (in_valid && in_ready) begin
            e     = model(a, b, s);
            e.acc = cyc;
            q.push_back(e);
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_S", S, '0);
        chk("rst_flags", {c_out, ovf, zero}, 3'b000);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] ex_s, input logic ex_c, input logic ex_o,
                          input logic ex_z);
        int  n;
        bit  seen;
        cycle(1'b1, a, b, s, 1'b1);
        n    = 0;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
            n++;
            if (out_valid) seen = 1;
        end
        chk("latency", n, 2);
        chk("dir_S", S, ex_s);
        chk("dir_flags", {c_out, ovf, zero}, {ex_c, ex_o, ex_z});
    endtask

    logic [W-1:0] xa[4];
    logic [W-1:0] xb[4];
    logic         xs[4];
    res_t         x0_exp;
    int           idx;
    int           sent;
    logic         v, s, r;
    logic [W-1:0] a, b;

    initial begin
        do_reset();

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Back-pressure: consumer stalls for four cycles while the producer keeps offering.
        for (int i = 0; i < 4; i++) begin
            xa[i] = $urandom;
            xb[i] = $urandom;
            xs[i] = 1'($urandom_range(0, 1));
        end
        x0_exp = model(xa[0], xb[0], xs[0]);
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, xa[idx], xb[idx], xs[idx], 1'b0);
            chk("bp_in_ready", in_ready, k < 2);
            if (in_valid && in_ready) idx++;
            if (k >= 2) chk("bp_frozen_S", S, x0_exp.s);
        end
        chk("bp_accepted", idx, 2);
        for (int k = 0; k < 4; k++) begin
            cycle(idx < 4, xa[idx % 4], xb[idx % 4], xs[idx % 4], 1'b1);
            if (in_valid && in_ready) idx++;
            chk("bp_no_gap", out_valid, 1'b1);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("bp_drained", q.size(), 0);

        // Random streaming with random valid and ready.
        sent = 0;
        for (int c = 0; c < 60000 && sent < NOPS; c++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 7);
            s = 1'($urandom_range(0, 1));
            a = rnd_op();
            b = rnd_op();
            cycle(v, a, b, s, r);
            if (in_valid && in_ready) sent++;
        end
        chk("rand_sent", sent, NOPS);
        for (int k = 0; k < 6; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        chk("rand_drained", q.size(), 0);

        // Reset with two ops in flight.
        cycle(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
        chk("final_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
